// File: rtl/round_robin_dispatch_if.sv
// Handshake and operand bus between the operand source, the dispatcher and
// its array of computational units. The dispatcher uses the slave modport;
// the surrounding environment (source plus units) uses the master modport.
interface round_robin_dispatch_if #(
    parameter int width     = 16,
    parameter int n_outputs = 4
);

    logic                                up_vld;
    logic [width-1:0]                    up_data;
    logic                                up_rdy;
    logic [n_outputs-1:0]                down_vlds;
    logic [n_outputs-1:0][width-1:0]     down_data;
    logic [n_outputs-1:0]                unit_done;

    modport master (
        output up_vld,
        output up_data,
        output unit_done,
        input  up_rdy,
        input  down_vlds,
        input  down_data
    );

    modport slave (
        input  up_vld,
        input  up_data,
        input  unit_done,
        output up_rdy,
        output down_vlds,
        output down_data
    );

endinterface

// File: rtl/round_robin_dispatch.sv
// Strict round-robin operand dispatcher for an array of non-pipelined,
// variable-latency units. Issue order is always 0,1,...,n-1,0,... so a
// downstream in-order collector can reassemble results. A unit is never
// re-issued until its previous result has come back; completions from idle
// units (including the collision of a completion with an issue to the same
// unit) latch a sticky error flag.
module round_robin_dispatch #(
    parameter int width     = 16,
    parameter int n_outputs = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    round_robin_dispatch_if.slave             bus,
    output logic [$clog2(n_outputs+1)-1:0]    in_flight,
    output logic                              err
);

    localparam int cw = $clog2(n_outputs + 1);
    localparam int pw = (n_outputs > 1) ? $clog2(n_outputs) : 1;

    logic [pw-1:0]                    ptr;
    logic [pw-1:0]                    ptr_next;
    logic [n_outputs-1:0]             busy;
    logic [n_outputs-1:0]             vlds_q;
    logic [n_outputs-1:0][width-1:0]  data_q;

    logic                             transfer;
    logic [n_outputs-1:0]             issue_mask;
    logic [n_outputs-1:0]             valid_done;
    logic [n_outputs-1:0]             bad_done;
    logic [cw-1:0]                    done_count;

    assign bus.up_rdy    = rst & ~busy[ptr];
    assign bus.down_vlds = vlds_q;
    assign bus.down_data = data_q;

    // Decode this cycle's transfer, the unit it targets, and classify completions.
    always_comb begin
        transfer   = bus.up_vld & bus.up_rdy;
        issue_mask = '0;
        issue_mask[ptr] = transfer;
        valid_done = bus.unit_done & busy;
        bad_done   = bus.unit_done & ~busy;
        ptr_next   = (ptr == pw'(n_outputs - 1)) ? '0 : ptr + pw'(1);
        done_count = '0;
        for (int i = 0; i < n_outputs; i++) begin
            done_count = done_count + cw'(valid_done[i]);
        end
    end

    // Issue pointer, busy flags, start pulses, operand registers, counter and error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            busy      <= '0;
            vlds_q    <= '0;
            data_q    <= '0;
            in_flight <= '0;
            err       <= 1'b0;
        end else begin
            vlds_q    <= issue_mask;
            busy      <= (busy & ~valid_done) | issue_mask;
            in_flight <= in_flight + cw'(transfer) - done_count;
            if (transfer) begin
                data_q[ptr] <= bus.up_data;
                ptr         <= ptr_next;
            end
            if (|bad_done) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_round_robin_dispatch.sv
// Self-checking bench for round_robin_dispatch (width 16, 4 units): a table
// of directed vectors, a short late-completion sequence after reset, and a
// randomized run with emulated variable-latency units. Issues predicted by
// the bench go through a scoreboard queue and are matched against start
// pulses one cycle later.
module tb_round_robin_dispatch;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] data;
        logic [3:0]  done;
        logic        rdy_pre;
        logic [3:0]  vlds;
        logic [2:0]  inf;
        logic        err;
    } vec_t;

    typedef struct {
        int          unit;
        logic [15:0] data;
    } issue_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_flight;
    logic        err;

    int          checks = 0;
    int          errors = 0;

    issue_t      sb[$];
    int          ptr_model = 0;
    logic [15:0] data_model[4];

    vec_t        vecs[25];
    int          n_vecs;

    round_robin_dispatch_if #(.width(16), .n_outputs(4)) bus ();

    round_robin_dispatch #(.width(16), .n_outputs(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .in_flight (in_flight),
        .err       (err)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic v, logic [15:0] d, logic [3:0] dn,
                                logic rp, logic [3:0] vl, logic [2:0] inf, logic e);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.done = dn;
        t.rdy_pre = rp; t.vlds = vl; t.inf = inf; t.err = e;
        return t;
    endfunction

    function automatic int pop4(logic [3:0] x);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(x[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [15:0] d, input logic [3:0] dn);
        rst           = r;
        bus.up_vld    = v;
        bus.up_data   = d;
        bus.unit_done = dn;
    endtask

    task automatic checkOutput(input logic [2:0] exp_inf, input logic exp_err);
        logic [3:0]       exp_v;
        logic [3:0][15:0] exp_d;
        issue_t           e;
        exp_v = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_v[e.unit] = 1'b1;
            check("issue_data", {48'd0, bus.down_data[e.unit]}, {48'd0, e.data});
        end
        check("down_vlds", {60'd0, bus.down_vlds}, {60'd0, exp_v});
        for (int i = 0; i < 4; i++) exp_d[i] = data_model[i];
        check("down_data", bus.down_data, exp_d);
        check("in_flight", {61'd0, in_flight}, {61'd0, exp_inf});
        check("err", {63'd0, err}, {63'd0, exp_err});
    endtask

    task automatic doCycle(input logic r, input logic v, input logic [15:0] d, input logic [3:0] dn,
                           input logic exp_rdy, input logic [2:0] exp_inf, input logic exp_err);
        issue_t e;
        applyStimulus(r, v, d, dn);
        #1;
        check("up_rdy", {63'd0, bus.up_rdy}, {63'd0, exp_rdy});
        if (!r) begin
            ptr_model = 0;
            for (int i = 0; i < 4; i++) data_model[i] = '0;
        end else if (v && exp_rdy) begin
            e.unit = ptr_model;
            e.data = d;
            sb.push_back(e);
            data_model[ptr_model] = d;
            ptr_model = (ptr_model + 1) % 4;
        end
        @(posedge clk);
        #1;
        checkOutput(exp_inf, exp_err);
    endtask

    // Directed table, late-completion sequence, then randomized traffic.
    initial begin
        logic [3:0]  r_busy;
        int          r_inf;
        int          timer[4];
        int          issued;
        int          cycles;
        logic [3:0]  dn;
        logic        v;
        logic        rdy_m;
        logic [15:0] d;
        int          inf_next;
        int          unit;

        for (int i = 0; i < 4; i++) data_model[i] = '0;

        vecs[0]  = mk(0, 0, 16'h0000, 4'b0000, 0, 4'b0000, 0, 0);
        vecs[1]  = mk(1, 1, 16'h0001, 4'b0000, 1, 4'b0001, 1, 0);
        vecs[2]  = mk(1, 1, 16'h0002, 4'b0000, 1, 4'b0010, 2, 0);
        vecs[3]  = mk(1, 1, 16'h0003, 4'b0000, 1, 4'b0100, 3, 0);
        vecs[4]  = mk(1, 1, 16'h0004, 4'b0000, 1, 4'b1000, 4, 0);
        vecs[5]  = mk(1, 1, 16'h0005, 4'b0100, 0, 4'b0000, 3, 0);
        vecs[6]  = mk(1, 1, 16'h0005, 4'b0010, 0, 4'b0000, 2, 0);
        vecs[7]  = mk(1, 1, 16'h0005, 4'b0001, 0, 4'b0000, 1, 0);
        vecs[8]  = mk(1, 1, 16'h0005, 4'b0000, 1, 4'b0001, 2, 0);
        vecs[9]  = mk(1, 0, 16'h0000, 4'b0100, 1, 4'b0000, 2, 1);
        vecs[10] = mk(1, 0, 16'h0000, 4'b0000, 1, 4'b0000, 2, 1);
        vecs[11] = mk(1, 1, 16'h0006, 4'b0000, 1, 4'b0010, 3, 1);
        vecs[12] = mk(1, 1, 16'h0007, 4'b1000, 1, 4'b0100, 3, 1);
        vecs[13] = mk(0, 1, 16'h00FF, 4'b0000, 0, 4'b0000, 0, 0);
        vecs[14] = mk(1, 1, 16'h00AA, 4'b0000, 1, 4'b0001, 1, 0);
        vecs[15] = mk(1, 1, 16'h00BB, 4'b0000, 1, 4'b0010, 2, 0);
        vecs[16] = mk(1, 1, 16'h00CC, 4'b0000, 1, 4'b0100, 3, 0);
        vecs[17] = mk(1, 1, 16'h00DD, 4'b0000, 1, 4'b1000, 4, 0);
        vecs[18] = mk(1, 0, 16'h0000, 4'b1111, 0, 4'b0000, 0, 0);
        vecs[19] = mk(1, 1, 16'h00EE, 4'b0000, 1, 4'b0001, 1, 0);
        vecs[20] = mk(1, 0, 16'h0000, 4'b0001, 1, 4'b0000, 0, 0);
        vecs[21] = mk(1, 1, 16'h0011, 4'b0010, 1, 4'b0010, 1, 1);
        n_vecs = 22;

        $display("[TB] directed table");
        for (int k = 0; k < n_vecs; k++) begin
            doCycle(vecs[k].rst, vecs[k].vld, vecs[k].data, vecs[k].done,
                    vecs[k].rdy_pre, vecs[k].inf, vecs[k].err);
            check($sformatf("vec%0d_vlds", k), {60'd0, bus.down_vlds}, {60'd0, vecs[k].vlds});
        end

        $display("[TB] late completion after reset");
        doCycle(0, 0, 16'h0000, 4'b0000, 0, 0, 0);
        doCycle(1, 0, 16'h0000, 4'b0010, 1, 0, 1);
        doCycle(1, 0, 16'h0000, 4'b0000, 1, 0, 1);

        $display("[TB] randomized traffic");
        doCycle(0, 0, 16'h0000, 4'b0000, 0, 0, 0);
        doCycle(0, 0, 16'h0000, 4'b0000, 0, 0, 0);
        r_busy = '0;
        r_inf  = 0;
        for (int i = 0; i < 4; i++) timer[i] = 0;
        issued = 0;
        cycles = 0;
        while ((issued < 1000 || r_inf != 0) && cycles < 30000) begin
            for (int i = 0; i < 4; i++) dn[i] = (timer[i] == 1);
            v        = (issued < 1000) ? ($urandom_range(0, 9) < 7) : 1'b0;
            d        = 16'($urandom);
            unit     = ptr_model;
            rdy_m    = ~r_busy[unit];
            inf_next = r_inf + int'(v & rdy_m) - pop4(dn & r_busy);
            doCycle(1, v, d, dn, rdy_m, 3'(inf_next), 0);
            r_busy = r_busy & ~dn;
            if (v && rdy_m) begin
                r_busy[unit] = 1'b1;
                issued++;
            end
            r_inf = inf_next;
            for (int i = 0; i < 4; i++) if (timer[i] > 0) timer[i]--;
            for (int i = 0; i < 4; i++) if (bus.down_vlds[i]) timer[i] = $urandom_range(1, 20);
            cycles++;
        end
        check("random_complete", {63'd0, (issued == 1000 && r_inf == 0)}, 64'd1);
        check("scoreboard_empty", sb.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
